// File: rtl/mem_except_ctrl.sv
// Memory-stage exception arbiter: combinational CP0 write bus, registered flush/redirect (N+1).
// Backpressure: redirect held until if_ready; new exceptions ignored while busy.
module mem_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter bit          PRIO_INT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic [31:0] mem_badaddr,
  input  logic [7:0]  mem_exc_flags,
  input  logic [95:0] cp0_bus,
  input  logic        if_ready,
  output logic [68:0] m_cp0_bus,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        except_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [3:0] CODE_NONE = 4'h0;
  localparam logic [3:0] CODE_INT  = 4'h1;
  localparam logic [3:0] CODE_ADEL = 4'h4;
  localparam logic [3:0] CODE_ADES = 4'h5;
  localparam logic [3:0] CODE_SYS  = 4'h8;
  localparam logic [3:0] CODE_BRK  = 4'h9;
  localparam logic [3:0] CODE_RI   = 4'ha;
  localparam logic [3:0] CODE_OV   = 4'hc;
  localparam logic [3:0] CODE_ERET = 4'he;

  state_t      state_q, state_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] status, cause, epc;
  logic        f_eret, f_adel_if, f_ri, f_ov, f_sys, f_brk, f_adel_d, f_ades_d;
  logic        int_pend;
  logic        take;
  logic        sel_eret;
  logic [3:0]  exc_code;
  logic [31:0] exc_badaddr;

  assign status = cp0_bus[95:64];
  assign cause  = cp0_bus[63:32];
  assign epc    = cp0_bus[31:0];

  assign {f_eret, f_adel_if, f_ri, f_ov, f_sys, f_brk, f_adel_d, f_ades_d} = mem_exc_flags;

  // IE set, EXL clear, and some unmasked interrupt line raised.
  assign int_pend = status[0] & ~status[1] & (|(status[15:8] & cause[15:8]));

  logic unused_cp0;
  assign unused_cp0 = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

  always_comb begin
    exc_code    = CODE_NONE;
    exc_badaddr = 32'h0;
    sel_eret    = 1'b0;
    if (PRIO_INT && int_pend) begin
      exc_code = CODE_INT;
    end else if (f_adel_if) begin
      exc_code    = CODE_ADEL;
      exc_badaddr = mem_pc;
    end else if (f_ri) begin
      exc_code = CODE_RI;
    end else if (f_ov) begin
      exc_code = CODE_OV;
    end else if (f_sys) begin
      exc_code = CODE_SYS;
    end else if (f_brk) begin
      exc_code = CODE_BRK;
    end else if (f_adel_d) begin
      exc_code    = CODE_ADEL;
      exc_badaddr = mem_badaddr;
    end else if (f_ades_d) begin
      exc_code    = CODE_ADES;
      exc_badaddr = mem_badaddr;
    end else if (!PRIO_INT && int_pend) begin
      exc_code = CODE_INT;
    end else if (f_eret) begin
      exc_code = CODE_ERET;
      sel_eret = 1'b1;
    end
  end

  // Gating on rst keeps the CP0 write bus quiet while reset is held.
  assign take = rst & mem_valid & (state_q == IDLE) & (int_pend | (|mem_exc_flags));

  always_comb begin
    m_cp0_bus = 69'h0;
    if (take) begin
      m_cp0_bus = {exc_badaddr, mem_delayslot, mem_pc, exc_code};
    end
  end

  always_comb begin
    state_d          = state_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d          = REDIRECT;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = sel_eret ? epc : EXC_VECTOR;
        end
      end
      REDIRECT: begin
        if (if_ready) begin
          state_d = DRAIN;
        end else begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign except_busy    = (state_q != IDLE);

  a_valid_in_redirect: assert property (@(posedge clk) disable iff (!rst)
    redirect_valid_q |-> (state_q == REDIRECT));
  a_flush_tracks_valid: assert property (@(posedge clk) disable iff (!rst)
    flush_q == redirect_valid_q);

endmodule

// File: doc/mem_except_ctrl.md
Name: mem_except_ctrl

Overview:
Memory-stage exception arbiter and redirect controller.
- Consumes per-instruction exception flags from the EX/MEM pipeline register and the live CP0 state bus {status, cause, epc}.
- Produces the 69-bit m_cp0_bus for the CP0 register file, plus a pipeline flush and a fetch redirect.
- Interrupts are decided here and attached to the instruction currently in MEM; a small FSM holds the redirect until fetch accepts it.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
PRIO_INT, 1, 1 = interrupt beats all synchronous exceptions; 0 = interrupt lowest priority

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
mem_valid  input  1  an instruction occupies MEM this cycle
mem_pc  input  32  PC of MEM instruction
mem_delayslot  input  1  MEM instruction is in a delay slot
mem_badaddr  input  32  faulting virtual address (fetch PC or data address)
mem_exc_flags  input  8  {eret, adel_if, ri, ov, syscall, brk, adel_d, ades_d}
cp0_bus  input  96  {status[31:0], cause[31:0], epc[31:0]} from CP0
if_ready  input  1  fetch accepts redirect this cycle
m_cp0_bus  output  69  {badaddr[32], delayslot[1], pc[32], except_info[4]} to CP0
flush  output  1  kill IF..MEM younger instructions
redirect_valid  output  1  redirect_pc is valid
redirect_pc  output  32  target PC
except_busy  output  1  FSM not in IDLE

Behaviour:
- Interrupt pending: int_pend = status[0] & ~status[1] & |(status[15:8] & cause[15:8]).
- except_info encoding and priority (PRIO_INT=1), highest first:
  int 4'h1 > adel_if 4'h4 > ri 4'ha > ov 4'hc > syscall 4'h8 > brk 4'h9 > adel_d 4'h4 > ades_d 4'h5 > eret 4'he > none 4'h0.
  With PRIO_INT=0, int is placed just above eret.
- take = mem_valid & state==IDLE & (int_pend | |mem_exc_flags).
- m_cp0_bus is combinational, same cycle as MEM.
  - When take: carries the chosen code, mem_pc, mem_delayslot.
  - badaddr field = mem_pc for adel_if, mem_badaddr for adel_d/ades_d, otherwise 0.
  - When not take: whole bus is 0, so except_info = 0 and CP0 holds.
- FSM states:
  - IDLE: on take, latch target and go to REDIRECT.
    - Target = cp0_bus epc field for eret (value sampled in the take cycle), otherwise EXC_VECTOR.
  - REDIRECT: redirect_valid=1, redirect_pc=latched target. If if_ready, go to DRAIN, else stay.
  - DRAIN: one cycle, redirect_valid=0, except_busy=1, lets CP0 EXL settle before the next take. Then go to IDLE.
- flush:
  - Registered one-cycle pulse in the cycle after take (state enters REDIRECT).
  - Also held high for every cycle in REDIRECT.
- redirect_pc and redirect_valid are registered; there is no combinational path from mem_* to redirect_*.
- except_busy = (state != IDLE).
- While busy, mem_valid is ignored: no take, and m_cp0_bus stays 0. Such instructions are wrong-path and are flushed.
- A new flag that arrives while if_ready is low is ignored; the redirect target never changes mid-handshake.
- Simultaneous int_pend and eret: the interrupt wins and eret is dropped. EPC gets the eret's PC via CP0 rules.
- Reset (async, rst=0): state=IDLE, flush=0, redirect_valid=0, redirect_pc=0, except_busy=0.
  - Reset asserted mid-REDIRECT drops the redirect immediately.
  - m_cp0_bus is combinational and is forced to 0 while rst=0.
- Latency: exception seen in MEM at cycle N gives flush and redirect_valid at N+1. Minimum spacing between two takes is 3 cycles.

Test Plan:
1. RI only: mem_valid=1, flags=8'h20, pc=0xBFC00100, if_ready=1.
   -> m_cp0_bus except_info=4'ha, pc=0xBFC00100 in cycle N; flush=1 and redirect_pc=0xBFC00380 at N+1; busy clears at N+3.
2. ERET with epc=0x80001234, if_ready low for 3 cycles.
   -> redirect_valid held 3 cycles with redirect_pc=0x80001234 and flush high throughout; DRAIN follows after if_ready rises.
3. Interrupt: status=0x00000401, cause[10]=1, flags=8'h04 (brk).
   -> except_info=4'h1, not 4'h9. Repeat with status[1]=1 -> except_info=4'h9.
4. Data AdES: flags=8'h01, badaddr=0x80000003.
   -> m_cp0_bus badaddr=0x80000003, except_info=4'h5. With adel_if also set -> code 4'h4, badaddr=mem_pc.
5. Flags asserted during REDIRECT/DRAIN.
   -> m_cp0_bus=0, no second take, redirect_pc unchanged.
6. Assert rst=0 mid-REDIRECT, off-clock-edge.
   -> redirect_valid, flush and except_busy drop asynchronously; after release the FSM is IDLE and the next exception is taken normally.
